// File: rtl/regfile_2r2w_shq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_2r2w_shq_pkg
// Purpose  : Shared definitions for the two-read/two-write shift-queue
//            register file. It holds the default geometry and the helpers
//            that derive the address and occupancy-counter widths from DEPTH.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package regfile_2r2w_shq_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 8;

    // Index width. DEPTH is at least 2, so the result is never below 1.
    // The max() guard keeps the helper safe if it is ever used elsewhere.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width of the occupancy counter. COUNT_W = AW + 1, so the counter can
    // hold the value DEPTH even when DEPTH is a power of two.
    function automatic int count_width(input int depth);
        return addr_width(depth) + 1;
    endfunction

endpackage : regfile_2r2w_shq_pkg
`default_nettype wire

// File: rtl/regfile_2r2w_shq_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_2r2w_shq_if
// Purpose  : Bundles the shift, write, read and status signals of the
//            register file.
// Ports    : master - drives qin/qdata, the write ports and the read
//                     addresses, and observes the read data and status.
//            slave  - the register file side.
//            Signals: qin, qdata, wen_a/waddr_a/wdata_a, wen_b/waddr_b/wdata_b,
//                     raddr_a/rdata_a, raddr_b/rdata_b, count, full, qout,
//                     qout_valid, wr_drop.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_2r2w_shq_if
    import regfile_2r2w_shq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
);
    localparam int AW      = addr_width(DEPTH);
    localparam int COUNT_W = count_width(DEPTH);

    logic               qin;
    logic [WIDTH-1:0]   qdata;
    logic               wen_a;
    logic [AW-1:0]      waddr_a;
    logic [WIDTH-1:0]   wdata_a;
    logic               wen_b;
    logic [AW-1:0]      waddr_b;
    logic [WIDTH-1:0]   wdata_b;
    logic [AW-1:0]      raddr_a;
    logic [WIDTH-1:0]   rdata_a;
    logic [AW-1:0]      raddr_b;
    logic [WIDTH-1:0]   rdata_b;
    logic [COUNT_W-1:0] count;
    logic               full;
    logic [WIDTH-1:0]   qout;
    logic               qout_valid;
    logic               wr_drop;

    modport master (
        output qin, qdata,
        output wen_a, waddr_a, wdata_a,
        output wen_b, waddr_b, wdata_b,
        output raddr_a, raddr_b,
        input  rdata_a, rdata_b,
        input  count, full, qout, qout_valid, wr_drop
    );

    modport slave (
        input  qin, qdata,
        input  wen_a, waddr_a, wdata_a,
        input  wen_b, waddr_b, wdata_b,
        input  raddr_a, raddr_b,
        output rdata_a, rdata_b,
        output count, full, qout, qout_valid, wr_drop
    );

endinterface : regfile_2r2w_shq_if
`default_nettype wire

// File: rtl/regfile_2r2w_shq_cell.sv
`default_nettype none
// ============================================================================
// Module   : regfile_cell
// Purpose  : One WIDTH-bit storage entry of the shift-queue register file.
//            The update priority is shift > write A > write B > hold.
// Ports    : clk, rst_n         - clock and asynchronous active-low reset
//            shift_en, shift_in - queue shift and the data from the previous
//                                 stage
//            wa_en, wa_data     - write from port A (already address-decoded)
//            wb_en, wb_data     - write from port B (already address-decoded)
//            q                  - stored value
// Revision : 1.0 - initial release
// ============================================================================
module regfile_cell
    import regfile_2r2w_shq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] shift_in,
    input  logic             wa_en,
    input  logic [WIDTH-1:0] wa_data,
    input  logic             wb_en,
    input  logic [WIDTH-1:0] wb_data,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (shift_en) begin
            r_q <= shift_in;
        end else if (wa_en) begin
            r_q <= wa_data;
        end else if (wb_en) begin
            r_q <= wb_data;
        end
    end

    assign q = r_q;

endmodule : regfile_cell
`default_nettype wire

// File: rtl/regfile_2r2w_shq.sv
`default_nettype none
// ============================================================================
// Module   : regfile_2r2w_shq
// Purpose  : A DEPTH x WIDTH register file with two indexed write ports, two
//            combinational read ports and a queue-shift mode. It also provides
//            occupancy tracking, an eviction output, write-drop reporting and
//            optional read-during-write bypass.
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous active-low reset
//            bus   - regfile_2r2w_shq_if.slave (shift, writes, reads, status)
// Revision : 1.0 - initial release
// ============================================================================
module regfile_2r2w_shq
    import regfile_2r2w_shq_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int BYPASS = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    regfile_2r2w_shq_if.slave  bus
);

    localparam int AW      = addr_width(DEPTH);
    localparam int COUNT_W = count_width(DEPTH);
    localparam logic [COUNT_W-1:0] c_depth = COUNT_W'(DEPTH);

    logic               w_a_in_range;
    logic               w_b_in_range;
    logic               w_collide;
    logic               w_a_accept;
    logic               w_b_accept;
    logic               w_drop;
    logic               w_full;
    logic [WIDTH-1:0]   w_entry [DEPTH];
    logic [WIDTH-1:0]   w_rdata_a;
    logic [WIDTH-1:0]   w_rdata_b;

    logic [COUNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_qout;
    logic               r_qout_valid;
    logic               r_wr_drop;

    // ------------------------------------------------------------------
    // Write decode. A shift suppresses both writes. On an address clash
    // port A wins, so port B is withdrawn and the clash is reported as a
    // drop.
    // ------------------------------------------------------------------
    assign w_a_in_range = ({1'b0, bus.waddr_a} < c_depth);
    assign w_b_in_range = ({1'b0, bus.waddr_b} < c_depth);
    assign w_collide    = bus.wen_a && bus.wen_b && (bus.waddr_a == bus.waddr_b);

    assign w_a_accept = !bus.qin && bus.wen_a && w_a_in_range;
    assign w_b_accept = !bus.qin && bus.wen_b && w_b_in_range && !w_collide;

    assign w_drop = bus.qin ? (bus.wen_a || bus.wen_b)
                            : ((bus.wen_a && !w_a_in_range) ||
                               (bus.wen_b && !w_b_in_range) ||
                               w_collide);

    assign w_full = (r_count == c_depth);

    // ------------------------------------------------------------------
    // Storage: one cell per entry. The shift input of each cell comes from
    // the previous entry; entry 0 takes qdata.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [WIDTH-1:0] w_shift_in;

        if (i == 0) begin : g_head
            assign w_shift_in = bus.qdata;
        end else begin : g_link
            assign w_shift_in = w_entry[i-1];
        end

        regfile_cell #(
            .WIDTH    (WIDTH)
        ) u_cell (
            .clk      (clk),
            .rst_n    (rst_n),
            .shift_en (bus.qin),
            .shift_in (w_shift_in),
            .wa_en    (w_a_accept && (bus.waddr_a == AW'(i))),
            .wa_data  (bus.wdata_a),
            .wb_en    (w_b_accept && (bus.waddr_b == AW'(i))),
            .wb_data  (bus.wdata_b),
            .q        (w_entry[i])
        );
    end

    // ------------------------------------------------------------------
    // Occupancy, eviction and pulse outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count      <= '0;
            r_qout       <= '0;
            r_qout_valid <= 1'b0;
            r_wr_drop    <= 1'b0;
        end else begin
            r_wr_drop <= w_drop;
            if (bus.qin) begin
                r_qout       <= w_entry[DEPTH-1];
                // The evicted entry is real only if every slot was filled by
                // a shift before this edge.
                r_qout_valid <= w_full;
                if (!w_full) begin
                    r_count <= r_count + COUNT_W'(1);
                end
            end else begin
                r_qout_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read muxes. The loop leaves the value at 0 for indices at or above
    // DEPTH. The bypass overlays are applied only to accepted writes,
    // which already exclude shift cycles and out-of-range indices. Port A
    // is applied last so that it wins when both ports hit.
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata_a = '0;
        w_rdata_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.raddr_a == AW'(i)) begin
                w_rdata_a = w_entry[i];
            end
            if (bus.raddr_b == AW'(i)) begin
                w_rdata_b = w_entry[i];
            end
        end
        if (BYPASS != 0) begin
            if (w_b_accept && (bus.waddr_b == bus.raddr_a)) w_rdata_a = bus.wdata_b;
            if (w_a_accept && (bus.waddr_a == bus.raddr_a)) w_rdata_a = bus.wdata_a;
            if (w_b_accept && (bus.waddr_b == bus.raddr_b)) w_rdata_b = bus.wdata_b;
            if (w_a_accept && (bus.waddr_a == bus.raddr_b)) w_rdata_b = bus.wdata_a;
        end
    end

    assign bus.rdata_a    = w_rdata_a;
    assign bus.rdata_b    = w_rdata_b;
    assign bus.count      = r_count;
    assign bus.full       = w_full;
    assign bus.qout       = r_qout;
    assign bus.qout_valid = r_qout_valid;
    assign bus.wr_drop    = r_wr_drop;

endmodule : regfile_2r2w_shq
`default_nettype wire

// File: tb/tb_regfile_2r2w_shq.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_2r2w_shq
// Purpose  : Directed self-checking bench for regfile_2r2w_shq. It drives two
//            instances with the same stimulus: one with BYPASS=1 and one with
//            BYPASS=0.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_2r2w_shq;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_2r2w_shq_if #(.WIDTH(8), .DEPTH(8)) bus1 ();
    regfile_2r2w_shq_if #(.WIDTH(8), .DEPTH(8)) bus0 ();

    // The BYPASS=0 instance mirrors the stimulus driven onto bus1.
    assign bus0.qin     = bus1.qin;
    assign bus0.qdata   = bus1.qdata;
    assign bus0.wen_a   = bus1.wen_a;
    assign bus0.waddr_a = bus1.waddr_a;
    assign bus0.wdata_a = bus1.wdata_a;
    assign bus0.wen_b   = bus1.wen_b;
    assign bus0.waddr_b = bus1.waddr_b;
    assign bus0.wdata_b = bus1.wdata_b;
    assign bus0.raddr_a = bus1.raddr_a;
    assign bus0.raddr_b = bus1.raddr_b;

    regfile_2r2w_shq #(.WIDTH(8), .DEPTH(8), .BYPASS(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    regfile_2r2w_shq #(.WIDTH(8), .DEPTH(8), .BYPASS(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus1.qin     = 1'b0;
        bus1.qdata   = '0;
        bus1.wen_a   = 1'b0;
        bus1.waddr_a = '0;
        bus1.wdata_a = '0;
        bus1.wen_b   = 1'b0;
        bus1.waddr_b = '0;
        bus1.wdata_b = '0;
        bus1.raddr_a = '0;
        bus1.raddr_b = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        check("rst_count", 16'(bus1.count), 16'd0);
        check("rst_full", 16'(bus1.full), 16'd0);
        check("rst_qvalid", 16'(bus1.qout_valid), 16'd0);
        check("rst_wr_drop", 16'(bus1.wr_drop), 16'd0);
        check("rst_rdata_a", 16'(bus1.rdata_a), 16'h00);
        rst_n = 1'b1;
        tick();

        // Dual write: A -> idx2 = 0x11, B -> idx5 = 0x22
        bus1.wen_a = 1'b1; bus1.waddr_a = 3'd2; bus1.wdata_a = 8'h11;
        bus1.wen_b = 1'b1; bus1.waddr_b = 3'd5; bus1.wdata_b = 8'h22;
        tick();
        idle();
        bus1.raddr_a = 3'd2; bus1.raddr_b = 3'd5;
        #1;
        check("dual_rd_a", 16'(bus1.rdata_a), 16'h11);
        check("dual_rd_b", 16'(bus1.rdata_b), 16'h22);
        check("dual_wr_drop", 16'(bus1.wr_drop), 16'd0);
        check("dual_count", 16'(bus1.count), 16'd0);
        check("dual_rd_b_nobyp", 16'(bus0.rdata_b), 16'h22);

        // Collision: both ports to idx3, port A wins
        bus1.wen_a = 1'b1; bus1.waddr_a = 3'd3; bus1.wdata_a = 8'hAA;
        bus1.wen_b = 1'b1; bus1.waddr_b = 3'd3; bus1.wdata_b = 8'hBB;
        bus1.raddr_a = 3'd3; bus1.raddr_b = 3'd3;
        #1;
        check("coll_bypass_b", 16'(bus1.rdata_b), 16'hAA);
        tick();
        idle();
        bus1.raddr_a = 3'd3;
        #1;
        check("coll_entry3", 16'(bus1.rdata_a), 16'hAA);
        check("coll_wr_drop", 16'(bus1.wr_drop), 16'd1);
        tick();
        check("coll_drop_clear", 16'(bus1.wr_drop), 16'd0);

        // Bypass: write 0x77 to idx6 while reading idx6
        bus1.wen_a = 1'b1; bus1.waddr_a = 3'd6; bus1.wdata_a = 8'h77;
        bus1.raddr_a = 3'd6;
        #1;
        check("byp1_same_cycle", 16'(bus1.rdata_a), 16'h77);
        check("byp0_same_cycle", 16'(bus0.rdata_a), 16'h00);
        tick();
        idle();
        bus1.raddr_a = 3'd6;
        #1;
        check("byp0_next_cycle", 16'(bus0.rdata_a), 16'h77);

        // Shift in 0x01..0x09
        for (int k = 1; k <= 9; k++) begin
            bus1.qin   = 1'b1;
            bus1.qdata = 8'(k);
            tick();
            if (k <= 8) begin
                check($sformatf("fill_count_%0d", k), 16'(bus1.count), 16'(k));
                check($sformatf("fill_qvalid_%0d", k), 16'(bus1.qout_valid), 16'd0);
                check($sformatf("fill_full_%0d", k), 16'(bus1.full), (k == 8) ? 16'd1 : 16'd0);
            end
        end
        check("evict_qout", 16'(bus1.qout), 16'h01);
        check("evict_qvalid", 16'(bus1.qout_valid), 16'd1);
        check("evict_count", 16'(bus1.count), 16'd8);
        check("evict_full", 16'(bus1.full), 16'd1);
        idle();
        bus1.raddr_a = 3'd0; bus1.raddr_b = 3'd7;
        #1;
        check("evict_entry0", 16'(bus1.rdata_a), 16'h09);
        check("evict_entry7", 16'(bus1.rdata_b), 16'h02);
        tick();
        check("evict_qvalid_clear", 16'(bus1.qout_valid), 16'd0);
        check("evict_qout_hold", 16'(bus1.qout), 16'h01);

        // Shift vs write: shift wins, write dropped, no bypass during shift
        bus1.qin = 1'b1; bus1.qdata = 8'h66;
        bus1.wen_a = 1'b1; bus1.waddr_a = 3'd0; bus1.wdata_a = 8'h55;
        bus1.raddr_a = 3'd0;
        #1;
        check("shw_no_bypass", 16'(bus1.rdata_a), 16'h09);
        tick();
        idle();
        bus1.raddr_a = 3'd0; bus1.raddr_b = 3'd1;
        #1;
        check("shw_entry0", 16'(bus1.rdata_a), 16'h66);
        check("shw_entry1", 16'(bus1.rdata_b), 16'h09);
        check("shw_wr_drop", 16'(bus1.wr_drop), 16'd1);
        check("shw_qout", 16'(bus1.qout), 16'h02);
        check("shw_qvalid", 16'(bus1.qout_valid), 16'd1);
        check("shw_count", 16'(bus1.count), 16'd8);

        // Asynchronous reset in the middle of a write cycle
        tick();
        bus1.wen_a = 1'b1; bus1.waddr_a = 3'd1; bus1.wdata_a = 8'hEE;
        bus1.raddr_a = 3'd0; bus1.raddr_b = 3'd7;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count", 16'(bus1.count), 16'd0);
        check("arst_full", 16'(bus1.full), 16'd0);
        check("arst_qvalid", 16'(bus1.qout_valid), 16'd0);
        check("arst_qout", 16'(bus1.qout), 16'h00);
        check("arst_rd_a", 16'(bus1.rdata_a), 16'h00);
        check("arst_rd_b", 16'(bus1.rdata_b), 16'h00);
        idle();
        tick();
        rst_n = 1'b1;
        tick();
        bus1.raddr_a = 3'd1;
        #1;
        check("arst_entry1", 16'(bus1.rdata_a), 16'h00);
        check("arst_wr_drop", 16'(bus1.wr_drop), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_regfile_2r2w_shq
`default_nettype wire
